// File: rtl/sevenseg_display_driver_if.sv
// Display-side signal bundle for the seven-segment driver: the value/blanking
// controls coming in and the multiplexed anode/segment drive going out.
interface sevenseg_display_driver_if;
    logic [15:0] display_value;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output display_value,
        output blank_lz,
        input  an,
        input  seg,
        input  dp,
        input  frame_done
    );

    modport slave (
        input  display_value,
        input  blank_lz,
        output an,
        output seg,
        output dp,
        output frame_done
    );
endinterface

// File: rtl/sevenseg_display_driver.sv
// Time-multiplexes a 16-bit value as four hex digits onto a common-anode
// seven-segment display, with frame-aligned capture, leading-zero blanking and an anode-off guard.
module sevenseg_display_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    sevenseg_display_driver_if.slave     bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic [1:0]    digit_sel;
    logic [15:0]   shadow;
    logic          tick;
    logic          guard;
    logic [1:0]    lead;
    logic          blanked;
    logic [3:0]    nibble;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] decode(input logic [3:0] value);
        case (value)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h08;
            4'hB:    decode = 7'h03;
            4'hC:    decode = 7'h46;
            4'hD:    decode = 7'h21;
            4'hE:    decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign tick = (div_cnt == CW'(REFRESH_DIV - 1));

    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign guard = 1'b0;
        end else begin : g_guard
            assign guard = ({1'b0, div_cnt} < (CW + 1)'(BLANK_CYCLES));
        end
    endgenerate

    // Scan state: slot divider, digit pointer and frame-aligned shadow copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt        <= '0;
            digit_sel      <= 2'd0;
            shadow         <= 16'h0000;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            if (tick) begin
                div_cnt   <= '0;
                digit_sel <= digit_sel + 2'd1;
                if (digit_sel == 2'd3) begin
                    shadow         <= bus.display_value;
                    bus.frame_done <= 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        lead = 2'd0;
        if (shadow[15:12] != 4'h0)     lead = 2'd3;
        else if (shadow[11:8] != 4'h0) lead = 2'd2;
        else if (shadow[7:4] != 4'h0)  lead = 2'd1;
    end

    assign blanked = bus.blank_lz && (digit_sel > lead);

    always_comb begin
        case (digit_sel)
            2'd0:    nibble = shadow[3:0];
            2'd1:    nibble = shadow[7:4];
            2'd2:    nibble = shadow[11:8];
            default: nibble = shadow[15:12];
        endcase
    end

    // Segments stay driven through the guard interval; only the anodes go dark.
    always_comb begin
        an_next  = ~(4'b0001 << digit_sel);
        seg_next = decode(nibble);
        if (blanked) begin
            an_next  = 4'b1111;
            seg_next = 7'h7F;
        end else if (guard) begin
            an_next  = 4'b1111;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.an  <= 4'b1111;
            bus.seg <= 7'h7F;
        end else begin
            bus.an  <= an_next;
            bus.seg <= seg_next;
        end
    end

    assign bus.dp = 1'b1;

endmodule

// File: tb/tb_sevenseg_display_driver.sv
// Directed bench for the seven-segment driver: frame vectors from a table plus
// hand sequences for start-up, mid-frame updates, decode sweep and async reset.
module tb_sevenseg_display_driver;

    typedef struct {
        logic [15:0]       value;
        logic              lz;
        logic [3:0][6:0]   segs;
        logic [3:0][3:0]   ans;
        string             name;
    } vec_t;

    logic clk;
    logic reset;

    sevenseg_display_driver_if dif ();
    sevenseg_display_driver_if zif ();

    sevenseg_display_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    sevenseg_display_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) dut_ng (
        .clk   (clk),
        .reset (reset),
        .bus   (zif)
    );

    int n_checks;
    int n_fail;

    localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    logic [6:0] dec_tab [16];
    vec_t       tab [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (dif.frame_done === 1'b1) seen = 1'b1;
        end
        chk({name, "_frame_wait"}, 32'(seen), 32'd1);
    endtask

    // Starts at the negedge right after a capture; ends on the last slot's first lit cycle.
    task automatic check_frame(input string name, input logic [3:0][6:0] segs,
                               input logic [3:0][3:0] ans);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            chk($sformatf("%s_guard_an_d%0d", name, d), 32'(dif.an), 32'hF);
            chk($sformatf("%s_guard_seg_d%0d", name, d), 32'(dif.seg), 32'(segs[d]));
            @(negedge clk);
            chk($sformatf("%s_an_d%0d", name, d), 32'(dif.an), 32'(ans[d]));
            chk($sformatf("%s_seg_d%0d", name, d), 32'(dif.seg), 32'(segs[d]));
            chk($sformatf("%s_fd_d%0d", name, d), 32'(dif.frame_done), 32'd0);
            chk($sformatf("%s_dp_d%0d", name, d), 32'(dif.dp), 32'd1);
            if (d < 3) begin
                @(negedge clk);
                @(negedge clk);
            end
        end
    endtask

    // From reset release: 16 cycles of scanning a zero shadow, capture on cycle 16.
    task automatic startup_check(input string name);
        logic [3:0] exp_an;
        logic [3:0] exp_an_ng;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            exp_an_ng = ~(4'b0001 << ((n - 1) / 4));
            exp_an    = (((n - 1) % 4) == 0) ? 4'b1111 : exp_an_ng;
            chk($sformatf("%s_an_c%0d", name, n), 32'(dif.an), 32'(exp_an));
            chk($sformatf("%s_seg_c%0d", name, n), 32'(dif.seg), 32'h40);
            chk($sformatf("%s_fd_c%0d", name, n), 32'(dif.frame_done), 32'(n == 16));
            chk($sformatf("%s_ng_an_c%0d", name, n), 32'(zif.an), 32'(exp_an_ng));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        tab[0] = '{16'h00F0, 1'b1, {7'h7F, 7'h7F, 7'h0E, 7'h40},
                   {4'b1111, 4'b1111, 4'b1101, 4'b1110}, "lz_00F0"};
        tab[1] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40},
                   {4'b1111, 4'b1111, 4'b1111, 4'b1110}, "lz_0000"};
        tab[2] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, AN_ALL, "nolz_0000"};
        tab[3] = '{16'h5678, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, AN_ALL, "val_5678"};
        tab[4] = '{16'h9EF0, 1'b1, {7'h10, 7'h06, 7'h0E, 7'h40}, AN_ALL, "lz_9EF0"};
        tab[5] = '{16'h0100, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40},
                   {4'b1111, 4'b1011, 4'b1101, 4'b1110}, "lz_0100"};

        reset             = 1'b1;
        dif.display_value = 16'h1234;
        dif.blank_lz      = 1'b0;
        zif.display_value = 16'h0000;
        zif.blank_lz      = 1'b0;
        #1;
        chk("rst_an", 32'(dif.an), 32'hF);
        chk("rst_seg", 32'(dif.seg), 32'h7F);
        chk("rst_dp", 32'(dif.dp), 32'd1);
        chk("rst_fd", 32'(dif.frame_done), 32'd0);

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        startup_check("start");
        check_frame("first_1234", {7'h79, 7'h24, 7'h30, 7'h19}, AN_ALL);

        // Input changes mid-frame must not disturb the frame being scanned.
        wait_frame("mid");
        dif.display_value = 16'hABCD;
        check_frame("mid_keep_1234", {7'h79, 7'h24, 7'h30, 7'h19}, AN_ALL);
        wait_frame("mid_new");
        check_frame("mid_abcd", {7'h08, 7'h03, 7'h46, 7'h21}, AN_ALL);

        for (int i = 0; i < 6; i++) begin
            dif.display_value = tab[i].value;
            dif.blank_lz      = tab[i].lz;
            wait_frame(tab[i].name);
            check_frame(tab[i].name, tab[i].segs, tab[i].ans);
        end

        dif.blank_lz = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dif.display_value = 16'(i);
            wait_frame($sformatf("sweep_%0h", i));
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("sweep_seg_%0h", i), 32'(dif.seg), 32'(dec_tab[i]));
            chk($sformatf("sweep_dp_%0h", i), 32'(dif.dp), 32'd1);
        end

        // Asynchronous reset while digit 2 is lit.
        dif.display_value = 16'h1234;
        wait_frame("areset");
        repeat (10) @(negedge clk);
        chk("areset_pre_an", 32'(dif.an), 32'hB);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_an", 32'(dif.an), 32'hF);
        chk("areset_seg", 32'(dif.seg), 32'h7F);
        chk("areset_fd", 32'(dif.frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        startup_check("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
